// File: rtl/morra_pkg.sv
// Shared encodings, state type and tournament defaults for the Morracinese scoreboard.
package morra_pkg;

  localparam int VITTORIE_DEF    = 3;
  localparam int MAX_PARTITE_DEF = 7;

  typedef enum logic [1:0] {
    MOSSA_NULLA = 2'b00,
    SASSO       = 2'b01,
    CARTA       = 2'b10,
    FORBICE     = 2'b11
  } mossa_t;

  // Shared by manche, partita and torneo
  typedef enum logic [1:0] {
    RIS_NESSUNO = 2'b00,
    RIS_G1      = 2'b01,
    RIS_G2      = 2'b10,
    RIS_PARI    = 2'b11
  } risultato_t;

  typedef enum logic {
    GIOCO = 1'b0,
    FINE  = 1'b1
  } stato_t;

  // Tournament verdict from post-increment tallies
  function automatic logic [1:0] esito_torneo(input logic [2:0] v1,
                                              input logic [2:0] v2,
                                              input logic [2:0] g,
                                              input logic [2:0] vittorie,
                                              input logic [2:0] max_partite);
    if (v1 == vittorie)         return RIS_G1;
    else if (v2 == vittorie)    return RIS_G2;
    else if (g == max_partite) begin
      if (v1 > v2)              return RIS_G1;
      else if (v1 < v2)         return RIS_G2;
      else                      return RIS_PARI;
    end
    return RIS_NESSUNO;
  endfunction

endpackage

// File: rtl/contatore_sat.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module contatore_sat #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (en && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/registro_torneo.sv
// Tournament scoreboard fed by the Morracinese FSMD: tallies matches and rounds
// and declares the winner, then freezes until the tournament reset.
module registro_torneo
  import morra_pkg::*;
#(
  parameter int VITTORIE    = VITTORIE_DEF,
  parameter int MAX_PARTITE = MAX_PARTITE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       reset_gioco,
  input  logic [1:0] manche,
  input  logic [1:0] partita,
  output logic [2:0] vinte1,
  output logic [2:0] vinte2,
  output logic [2:0] giocate,
  output logic [7:0] manche_valide,
  output logic [7:0] manche_pari,
  output logic       fine_partita,
  output logic [1:0] torneo
);

  localparam logic [2:0] VITT = 3'(VITTORIE);
  localparam logic [2:0] MAXP = 3'(MAX_PARTITE);

  stato_t     stato, stato_n;
  logic [1:0] partita_prev;
  logic       evento, conta_manche, conta_pari;
  logic [2:0] vinte1_n, vinte2_n, giocate_n;
  logic [1:0] torneo_n;

  always_comb begin
    stato_n   = stato;
    vinte1_n  = vinte1;
    vinte2_n  = vinte2;
    giocate_n = giocate;
    torneo_n  = torneo;
    // A result is scored only on its first cycle after an in-progress cycle
    evento = (stato == GIOCO) && !reset_gioco &&
             (partita != RIS_NESSUNO) && (partita_prev == RIS_NESSUNO);
    conta_manche = (stato == GIOCO) && !reset_gioco && (manche != RIS_NESSUNO);
    conta_pari   = conta_manche && (manche == RIS_PARI);
    if (evento) begin
      giocate_n = giocate + 3'd1;
      if (partita == RIS_G1)      vinte1_n = vinte1 + 3'd1;
      else if (partita == RIS_G2) vinte2_n = vinte2 + 3'd1;
      torneo_n = esito_torneo(vinte1_n, vinte2_n, giocate_n, VITT, MAXP);
      if (torneo_n != RIS_NESSUNO) stato_n = FINE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stato        <= GIOCO;
      partita_prev <= RIS_NESSUNO;
      vinte1       <= '0;
      vinte2       <= '0;
      giocate      <= '0;
      fine_partita <= 1'b0;
      torneo       <= RIS_NESSUNO;
    end else begin
      stato        <= stato_n;
      partita_prev <= reset_gioco ? RIS_NESSUNO : partita;
      vinte1       <= vinte1_n;
      vinte2       <= vinte2_n;
      giocate      <= giocate_n;
      fine_partita <= evento;
      torneo       <= torneo_n;
    end
  end

  contatore_sat #(.W(8)) u_manche_valide (
    .clk   (clk),
    .clr   (reset),
    .en    (conta_manche),
    .count (manche_valide)
  );

  contatore_sat #(.W(8)) u_manche_pari (
    .clk   (clk),
    .clr   (reset),
    .en    (conta_pari),
    .count (manche_pari)
  );

endmodule

// File: tb/tb_registro_torneo.sv
// Bench for registro_torneo: directed vector table, hand sequences for the
// multi-cycle corners, then random traffic against a behavioural scoreboard.
module tb_registro_torneo;

  localparam int VITTORIE    = 3;
  localparam int MAX_PARTITE = 7;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       reset_gioco = 1'b0;
  logic [1:0] manche = 2'b00;
  logic [1:0] partita = 2'b00;
  logic [2:0] vinte1, vinte2, giocate;
  logic [7:0] manche_valide, manche_pari;
  logic       fine_partita;
  logic [1:0] torneo;

  int checks = 0;
  int errors = 0;

  registro_torneo #(.VITTORIE(VITTORIE), .MAX_PARTITE(MAX_PARTITE)) dut (
    .clk           (clk),
    .reset         (reset),
    .reset_gioco   (reset_gioco),
    .manche        (manche),
    .partita       (partita),
    .vinte1        (vinte1),
    .vinte2        (vinte2),
    .giocate       (giocate),
    .manche_valide (manche_valide),
    .manche_pari   (manche_pari),
    .fine_partita  (fine_partita),
    .torneo        (torneo)
  );

  always #5 clk = ~clk;

  // Behavioural scoreboard: plain integer tallies following the tournament rules
  int m_v1, m_v2, m_g, m_mv, m_mp, m_pulse, m_tor, m_prev;
  bit m_done;

  function automatic int verdict(int v1, int v2, int g);
    if (v1 == VITTORIE) return 1;
    if (v2 == VITTORIE) return 2;
    if (g == MAX_PARTITE) return (v1 > v2) ? 1 : (v1 < v2) ? 2 : 3;
    return 0;
  endfunction

  task automatic model_step(input bit r, input bit rg, input int man, input int par);
    if (r) begin
      m_v1 = 0; m_v2 = 0; m_g = 0; m_mv = 0; m_mp = 0;
      m_pulse = 0; m_tor = 0; m_prev = 0; m_done = 0;
      return;
    end
    m_pulse = 0;
    if (!m_done && !rg) begin
      if (man != 0) m_mv = (m_mv < 255) ? m_mv + 1 : 255;
      if (man == 3) m_mp = (m_mp < 255) ? m_mp + 1 : 255;
      if (par != 0 && m_prev == 0) begin
        m_pulse = 1;
        m_g++;
        if (par == 1) m_v1++;
        if (par == 2) m_v2++;
        m_tor = verdict(m_v1, m_v2, m_g);
        if (m_tor != 0) m_done = 1;
      end
    end
    m_prev = rg ? 0 : par;
  endtask

  task automatic step(input logic r, input logic rg, input logic [1:0] m, input logic [1:0] p);
    reset = r; reset_gioco = rg; manche = m; partita = p;
    model_step(r, rg, int'(m), int'(p));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] dut_all();
    return {vinte1, vinte2, giocate, manche_valide, manche_pari, fine_partita, torneo};
  endfunction

  function automatic logic [27:0] model_all();
    return {3'(m_v1), 3'(m_v2), 3'(m_g), 8'(m_mv), 8'(m_mp), 1'(m_pulse), 2'(m_tor)};
  endfunction

  task automatic check(input string name, input logic [27:0] got, input logic [27:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       rg;
    logic [1:0] man;
    logic [1:0] par;
    logic [2:0] v1;
    logic [2:0] v2;
    logic [2:0] g;
    logic       fp;
    logic [1:0] tor;
  } vec_t;

  vec_t vecs[16];
  logic [1:0] seq7[7];
  logic [1:0] rnd_par;

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0, 2'b00};
    vecs[1]  = '{1'b0, 1'b0, 2'b01, 2'b01, 3'd1, 3'd0, 3'd1, 1'b1, 2'b00};
    vecs[2]  = '{1'b0, 1'b0, 2'b00, 2'b01, 3'd1, 3'd0, 3'd1, 1'b0, 2'b00};
    vecs[3]  = '{1'b0, 1'b1, 2'b00, 2'b00, 3'd1, 3'd0, 3'd1, 1'b0, 2'b00};
    vecs[4]  = '{1'b0, 1'b0, 2'b01, 2'b01, 3'd2, 3'd0, 3'd2, 1'b1, 2'b00};
    vecs[5]  = '{1'b0, 1'b1, 2'b00, 2'b00, 3'd2, 3'd0, 3'd2, 1'b0, 2'b00};
    vecs[6]  = '{1'b0, 1'b0, 2'b01, 2'b01, 3'd3, 3'd0, 3'd3, 1'b1, 2'b01};
    vecs[7]  = '{1'b0, 1'b0, 2'b00, 2'b00, 3'd3, 3'd0, 3'd3, 1'b0, 2'b01};
    vecs[8]  = '{1'b0, 1'b0, 2'b01, 2'b01, 3'd3, 3'd0, 3'd3, 1'b0, 2'b01};
    vecs[9]  = '{1'b0, 1'b0, 2'b10, 2'b10, 3'd3, 3'd0, 3'd3, 1'b0, 2'b01};
    vecs[10] = '{1'b1, 1'b0, 2'b00, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0, 2'b00};
    vecs[11] = '{1'b0, 1'b0, 2'b10, 2'b10, 3'd0, 3'd1, 3'd1, 1'b1, 2'b00};
    for (int i = 12; i < 16; i++)
      vecs[i] = '{1'b0, 1'b0, 2'b00, 2'b10, 3'd0, 3'd1, 3'd1, 1'b0, 2'b00};
    seq7 = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};

    step(1'b1, 1'b0, 2'b00, 2'b00);
    check("reset_state", dut_all(), 28'd0);

    // Directed table: three g1 wins, frozen FINE, reset, held g2 result
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].rg, vecs[i].man, vecs[i].par);
      check($sformatf("vec%0d", i),
            {16'd0, vinte1, vinte2, giocate, fine_partita, torneo},
            {16'd0, vecs[i].v1, vecs[i].v2, vecs[i].g, vecs[i].fp, vecs[i].tor});
    end

    // Seven scored matches ending level
    step(1'b1, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, seq7[i], seq7[i]);
      if (i == 5)
        check("draw_before_last", {16'd0, vinte1, vinte2, giocate, fine_partita, torneo},
              {16'd0, 3'd2, 3'd2, 3'd6, 1'b1, 2'b00});
      step(1'b0, 1'b1, 2'b00, 2'b00);
    end
    check("draw_final", {16'd0, vinte1, vinte2, giocate, fine_partita, torneo},
          {16'd0, 3'd2, 3'd2, 3'd7, 1'b0, 2'b11});
    step(1'b0, 1'b0, 2'b01, 2'b01);
    check("draw_frozen", {16'd0, vinte1, vinte2, giocate, fine_partita, torneo},
          {16'd0, 3'd2, 3'd2, 3'd7, 1'b0, 2'b11});

    // Round counters saturate
    step(1'b1, 1'b0, 2'b00, 2'b00);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b0, 2'b11, 2'b00);
      if (i == 254)
        check("sat_reach", {12'd0, manche_valide, manche_pari}, {12'd0, 8'd255, 8'd255});
    end
    check("sat_hold", {12'd0, manche_valide, manche_pari}, {12'd0, 8'd255, 8'd255});

    // Aborted match, then one event; reset coinciding with an event
    step(1'b1, 1'b0, 2'b00, 2'b00);
    step(1'b0, 1'b0, 2'b01, 2'b00);
    step(1'b0, 1'b1, 2'b00, 2'b00);
    check("abort_nochange", {19'd0, vinte1, giocate, fine_partita, torneo}, 28'd0);
    step(1'b0, 1'b0, 2'b10, 2'b01);
    check("after_abort_evt", {19'd0, vinte1, giocate, fine_partita, torneo},
          {19'd0, 3'd1, 3'd1, 1'b1, 2'b00});
    step(1'b0, 1'b0, 2'b00, 2'b01);
    check("after_abort_hold", {19'd0, vinte1, giocate, fine_partita, torneo},
          {19'd0, 3'd1, 3'd1, 1'b0, 2'b00});
    step(1'b0, 1'b0, 2'b00, 2'b00);
    step(1'b1, 1'b0, 2'b11, 2'b10);
    check("reset_wins", dut_all(), 28'd0);

    // Random traffic against the scoreboard
    step(1'b1, 1'b0, 2'b00, 2'b00);
    rnd_par = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rnd_par = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 9) == 0),
           2'($urandom_range(0, 3)), rnd_par);
      check("random", dut_all(), model_all());
      if (errors > 20) break;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/registro_torneo.md
REGISTRO_TORNEO -- requirements
Module: registro_torneo

Interface
REQ-001 The block SHALL use one clock `clk`; `reset` is synchronous and active-high.
REQ-002 Parameter: VITTORIE, 3, number of match wins that decides the tournament (1..7).
REQ-003 Parameter: MAX_PARTITE, 7, maximum number of scored matches (VITTORIE..7).
REQ-004 Port: clk  in  1  rising-edge clock shared with the upstream Morracinese FSMD.
REQ-005 Port: reset  in  1  synchronous active-high tournament reset.
REQ-006 Port: reset_gioco  in  1  the FSMD's per-match reset, observed only and not driven.
REQ-007 Port: manche  in  2  FSMD round result: 00 invalid, 01 g1, 10 g2, 11 tie.
REQ-008 Port: partita  in  2  FSMD match result: 00 in progress, 01 g1, 10 g2, 11 tie.
REQ-009 Port: vinte1 / vinte2  out  3  matches won by g1 / g2.
REQ-010 Port: giocate  out  3  scored matches, including ties.
REQ-011 Port: manche_valide  out  8  saturating count of valid rounds (manche != 00).
REQ-012 Port: manche_pari  out  8  saturating count of tied rounds (manche == 11).
REQ-013 Port: fine_partita  out  1  one-cycle registered pulse when a match result is scored.
REQ-014 Port: torneo  out  2  tournament result: 00 running, 01 g1, 10 g2, 11 draw.

Function
REQ-015 The block SHALL have two states: GIOCO (accepting results) and FINE (decided; outputs frozen).
REQ-016 The block SHALL register `partita` into `partita_prev` every cycle; when `reset_gioco`=1, `partita_prev` SHALL load 00 instead.
REQ-017 A scoring event SHALL occur, in state GIOCO with `reset_gioco`=0, when `partita` != 00 and `partita_prev` == 00.
REQ-018 At the edge that samples an event, the block SHALL increment `giocate`, plus `vinte1` if `partita`=01 or `vinte2` if `partita`=10; a tie (11) SHALL increment `giocate` only.
REQ-019 `fine_partita` SHALL be 1 for exactly the cycle after the sampling edge (latency 1), and 0 otherwise.
REQ-020 A held non-00 `partita` SHALL NOT produce a second event until `partita` returns to 00 or `reset_gioco` is asserted.
REQ-021 In GIOCO with `reset_gioco`=0, each cycle with `manche` != 00 SHALL increment `manche_valide`, and `manche`=11 SHALL also increment `manche_pari`; this includes the final round, whose result coincides with the event.
REQ-022 Both round counters SHALL saturate at 255 and SHALL NOT wrap.
REQ-023 At the event edge, the block SHALL compute `torneo` from the post-increment values:
- 01 if vinte1 == VITTORIE;
- 10 if vinte2 == VITTORIE;
- otherwise, if giocate == MAX_PARTITE: 01 if vinte1 > vinte2, 10 if vinte1 < vinte2, 11 if equal;
- otherwise 00.
REQ-024 The state SHALL move to FINE on the same edge that `torneo` becomes non-00.
REQ-025 In FINE, all inputs except `reset` SHALL be ignored and all counters and `torneo` SHALL hold.
REQ-026 A match aborted by `reset_gioco` before `partita` != 00 SHALL leave `vinte1`, `vinte2` and `giocate` unchanged.
REQ-027 If `reset` and an event coincide, `reset` SHALL win.

Reset
REQ-028 On `reset`=1 at a clock edge, the block SHALL enter state GIOCO and clear `partita_prev`, `vinte1`, `vinte2`, `giocate`, `manche_valide`, `manche_pari`, `fine_partita` and `torneo` to 0.
REQ-029 `reset` SHALL be honoured in any state, including mid-match and FINE.

Structure
REQ-030 Package `morra_pkg` SHALL hold:
- the move encodings (01 sasso, 10 carta, 11 forbice);
- the result encodings for manche/partita/torneo;
- the state enum;
- the VITTORIE and MAX_PARTITE defaults.
REQ-031 The 8-bit saturating round counters SHALL be instances of one sub-module, `contatore_sat` (enable, sync clear, saturate at all-ones).

Verification
REQ-032 g1 wins 3 matches (each partita 00->01, separated by reset_gioco) -> vinte1=3, giocate=3, torneo=01 after the 3rd event, state FINE.
REQ-033 partita held at 10 for 5 cycles without reset_gioco -> exactly one fine_partita pulse, vinte2=1.
REQ-034 Sequence tie, g1, g2, tie, g1, g2, tie -> giocate=7, vinte1=vinte2=2, torneo=11.
REQ-035 After FINE, a further partita=01 event -> no pulse, all counters unchanged; then `reset` -> all outputs 0.
REQ-036 300 cycles of manche=11 -> manche_valide=255, manche_pari=255, no wrap.
REQ-037 reset_gioco asserted mid-match, then partita=01 -> exactly one event counted; `reset` coincident with an event -> all outputs 0, no pulse.
